wbs_bridge_arbiter: RTL and testbench
=====================================

Name: wbs_bridge_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter.
- Shares the instruction-memory Wishbone slave port between the UART loader bridge (master 0) and the Caravel management Wishbone (master 1).
- Grants are round-robin, held for a whole cycle (cyc) and ack-routed to the owner.
- A watchdog terminates transfers the slave never acknowledges.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 16, address bus width.
- TIMEOUT_CYCLES, 255, cycles of unacknowledged stb before forced termination; minimum 2. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (UART bridge) cycle, strobe, write enable.
- m0_adr_i  in  ADDR_WIDTH  master 0 address.
- m0_dat_i  in  DATA_WIDTH  master 0 write data.
- m0_dat_o  out  DATA_WIDTH  read data to master 0.
- m0_ack_o, m0_err_o  out  1 each  acknowledge and error to master 0.
- m1_*  same set as m0_*  master 1 (management Wishbone).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave acknowledge.
- grant_o  out  2  one-hot current owner; 00 when idle.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, owner cleared, last_grant=1, timeout counter=0.
  - All outputs 0 from the next edge.
  - Reset mid-transfer drops s_cyc_o/s_stb_o immediately. A late s_ack_i is ignored.
- States: IDLE, BUSY, ERR.
- IDLE:
  - s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_dat_o driven 0; grant_o=00.
  - Request = mX_cyc_i.
  - Only one requester: grant it.
  - Both requesting: grant the master that is not last_grant.
  - A grant registers at the edge: request at edge N gives BUSY with grant_o valid after N; the slave sees signals in cycle N+1. Arbitration latency is 1 cycle.
- BUSY:
  - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o are combinationally muxed from the owner.
  - mOwner_ack_o = s_ack_i (combinational, zero latency).
  - The non-owner sees ack=0 and err=0.
  - s_dat_i is broadcast to both m0_dat_o and m1_dat_o.
  - Owner holds the grant while its cyc_i=1, including multiple stb/ack beats.
  - Owner cyc_i=0: next edge goes to IDLE and sets last_grant=owner. There is no same-edge regrant, so at least one IDLE cycle separates owners.
  - Slave ack while the owner drops cyc in the same cycle is still forwarded.
- Watchdog:
  - Counter increments each BUSY cycle with owner stb=1 and s_ack_i=0.
  - Clears on s_ack_i, on stb=0 and on leaving BUSY.
  - When counter==TIMEOUT_CYCLES-1 with no ack, next edge enters ERR.
- ERR (exactly 1 cycle):
  - s_cyc_o=s_stb_o=0.
  - mOwner_err_o=1, timeout_o=1.
  - Then IDLE, with last_grant=owner.
  - If the master still asserts cyc, it re-arbitrates normally.
- ack and err are never both 1 to a master.
- s_ack_i in IDLE or ERR is ignored.
- No width arithmetic beyond the counter; the counter saturates (never wraps) because ERR is taken first.

Test Plan:
- Single master: m0 write, adr=0x0010, dat=0xDEADBEEF.
  - Required: grant_o=01 one cycle after cyc.
  - Required: s_adr_o=0x0010, s_dat_o=0xDEADBEEF, s_we_o=1.
  - Required: slave ack after 2 cycles gives m0_ack_o in the same cycle; m1_ack_o=0.
- Contention from reset: m0 and m1 both raise cyc in the same cycle.
  - Required: m0 granted first (last_grant=1).
  - Required: after m0 drops cyc, one IDLE cycle, then m1 granted.
  - Required: repeat with both requesting → m0 again (alternation).
- Held grant: m1 does 3 back-to-back read beats (s_dat_i=0x1,0x2,0x3) while m0 requests.
  - Required: m0 is not granted until m1 cyc=0.
  - Required: m1 receives 0x1, 0x2, 0x3 on its acks.
- Timeout: TIMEOUT_CYCLES=4; m0 strobes and the slave never acks.
  - Required: after 4 stb cycles, m0_err_o=1 and timeout_o=1 for 1 cycle.
  - Required: s_cyc_o=0 in the ERR cycle, then IDLE.
- Reset mid-transfer: rst_n=0 while m1 is owner and stb=1.
  - Required: at the next edge all outputs=0, grant_o=00.
  - Required: s_ack_i pulsed during and after reset produces no m1_ack_o.
- Ack/drop coincidence: owner drops cyc in the same cycle as s_ack_i=1.
  - Required: ack is forwarded.
  - Required: next cycle is IDLE; the other pending master is granted the cycle after.

Source files
------------

// File: rtl/wbs_bridge_arbiter.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for a whole cyc,
// ack/err routed to the owner, watchdog forcing an error on a silent slave.
module wbs_bridge_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  // Handshake: a beat completes in any cycle where the owner's stb and s_ack_i
  // are both high while BUSY; the ack reaches the owner combinationally.
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_t;

  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic                  own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [DATA_WIDTH-1:0] own_dat;
  logic                  busy, err_st;

  always_comb begin
    own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    own_stb = owner_q ? m1_stb_i : m0_stb_i;
    own_we  = owner_q ? m1_we_i  : m0_we_i;
    own_adr = owner_q ? m1_adr_i : m0_adr_i;
    own_dat = owner_q ? m1_dat_i : m0_dat_i;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (m0_cyc_i || m1_cyc_i) begin
          state_d = ST_BUSY;
          // Under contention the master that did not own the bus last wins.
          owner_d = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (own_stb && !s_ack_i) begin
          if (cnt_q == CNT_LIMIT) begin
            state_d = ST_ERR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Qualifying with rst_n releases the slave bus in the very cycle reset is asserted.
  assign busy   = rst_n && (state_q == ST_BUSY);
  assign err_st = rst_n && (state_q == ST_ERR);

  always_comb begin
    s_cyc_o   = busy && own_cyc;
    s_stb_o   = busy && own_stb;
    s_we_o    = busy && own_we;
    s_adr_o   = busy ? own_adr : '0;
    s_dat_o   = busy ? own_dat : '0;
    m0_dat_o  = busy ? s_dat_i : '0;
    m1_dat_o  = busy ? s_dat_i : '0;
    m0_ack_o  = busy && !owner_q && s_ack_i;
    m1_ack_o  = busy &&  owner_q && s_ack_i;
    m0_err_o  = err_st && !owner_q;
    m1_err_o  = err_st &&  owner_q;
    timeout_o = err_st;
    grant_o   = (busy || err_st) ? {owner_q, ~owner_q} : 2'b00;
  end

endmodule

// File: tb/tb_wbs_bridge_arbiter.sv
// Scenario bench for wbs_bridge_arbiter: inputs change on the falling edge, checks
// run 1ns later; every forwarded ack is matched against a queue of expected beats.
module tb_wbs_bridge_arbiter;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int W  = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [AW-1:0] m0_adr_i = '0;
  logic [DW-1:0] m0_dat_i = '0;
  logic [DW-1:0] m0_dat_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [AW-1:0] m1_adr_i = '0;
  logic [DW-1:0] m1_dat_i = '0;
  logic [DW-1:0] m1_dat_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat_i = '0;
  logic          s_ack_i = 0;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  wbs_bridge_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, required finish before 200000ns");
    $fatal(1, "time limit");
  end

  // scoreboard: every ack seen by a master must match the next expected beat
  always @(negedge clk) begin
    #2;
    if (m0_ack_o || m1_ack_o) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack: got ack m1/m0=%b%b dat=%h, required no ack",
                 m1_ack_o, m0_ack_o, m1_ack_o ? m1_dat_o : m0_dat_o);
      end else begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        e = exp_q.pop_front();
        a = {m1_ack_o, m0_ack_o, (m1_ack_o ? m1_dat_o : m0_dat_o)};
        if (a !== e) begin
          n_err++;
          $display("FAIL ack_beat: got ack=%b dat=%h, required ack=%b dat=%h",
                   a[W-1:W-2], a[DW-1:0], e[W-1:W-2], e[DW-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic clear_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0;
    s_ack_i = 0; s_dat_i = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, timeout_o, m0_err_o, m1_err_o} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got grant=%b cyc=%b stb=%b we=%b to=%b err=%b%b, required all 0",
               grant_o, s_cyc_o, s_stb_o, s_we_o, timeout_o, m1_err_o, m0_err_o);
    end
    n_vec++;
    if ({s_adr_o, s_dat_o, m0_dat_o, m1_dat_o} !== '0) begin
      n_err++;
      $display("FAIL reset_buses: got adr=%h dat=%h, required 0", s_adr_o, s_dat_o);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 16'h0010; m0_dat_i = 32'hDEADBEEF;
    #1;
    n_vec++;
    if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency: got grant=%b cyc=%b, required 00/0", grant_o, s_cyc_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b01) begin
      n_err++;
      $display("FAIL single_grant: got %b, required 01", grant_o);
    end
    n_vec++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o} !== {3'b111, 16'h0010, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL single_mux: got cyc/stb/we=%b%b%b adr=%h dat=%h, required 111 0010 deadbeef",
               s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o);
    end
    @(negedge clk);
    s_ack_i = 1; s_dat_i = '0;
    exp_q.push_back({2'b01, 32'h0});
    #1;
    n_vec++;
    if ({m0_ack_o, m1_ack_o, m0_err_o} !== 3'b100) begin
      n_err++;
      $display("FAIL single_ack: got m0_ack=%b m1_ack=%b m0_err=%b, required 1 0 0",
               m0_ack_o, m1_ack_o, m0_err_o);
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b00) begin
      n_err++;
      $display("FAIL single_release: got grant=%b, required 00", grant_o);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    m0_cyc_i = 1; m1_cyc_i = 1;
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b01) begin
      n_err++;
      $display("FAIL contention_first: got %b, required 01", grant_o);
    end
    @(negedge clk);
    m0_cyc_i = 0;
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b00) begin
      n_err++;
      $display("FAIL contention_gap: got %b, required 00", grant_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b10) begin
      n_err++;
      $display("FAIL contention_second: got %b, required 10", grant_o);
    end
    m1_cyc_i = 0;
    m0_cyc_i = 1;
    @(negedge clk);
    m1_cyc_i = 1;
    #1;
    n_vec++;
    if (grant_o !== 2'b00) begin
      n_err++;
      $display("FAIL contention_gap2: got %b, required 00", grant_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b01) begin
      n_err++;
      $display("FAIL contention_alternate: got %b, required 01", grant_o);
    end
    clear_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_held_grant();
    logic [DW-1:0] beat;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 16'h0200;
    @(negedge clk);
    m0_cyc_i = 1; m0_stb_i = 1;
    #1;
    n_vec++;
    if (grant_o !== 2'b10) begin
      n_err++;
      $display("FAIL held_grant: got %b, required 10", grant_o);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      beat = DW'(i);
      s_ack_i = 1; s_dat_i = beat;
      exp_q.push_back({2'b10, beat});
      #1;
      n_vec++;
      if (grant_o !== 2'b10 || m0_ack_o !== 1'b0) begin
        n_err++;
        $display("FAIL held_beat%0d: got grant=%b m0_ack=%b, required 10 0", i, grant_o, m0_ack_o);
      end
    end
    @(negedge clk);
    s_ack_i = 0; s_dat_i = '0; m1_cyc_i = 0; m1_stb_i = 0;
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b00) begin
      n_err++;
      $display("FAIL held_gap: got %b, required 00", grant_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b01) begin
      n_err++;
      $display("FAIL held_handover: got %b, required 01", grant_o);
    end
    clear_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0444;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({grant_o, s_cyc_o, m0_err_o, timeout_o} !== 5'b01100) begin
        n_err++;
        $display("FAIL timeout_wait%0d: got grant=%b cyc=%b err=%b to=%b, required 01 1 0 0",
                 i, grant_o, s_cyc_o, m0_err_o, timeout_o);
      end
    end
    @(negedge clk);
    s_ack_i = 1;
    m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    n_vec++;
    if ({m0_err_o, timeout_o, s_cyc_o, s_stb_o, m1_err_o} !== 5'b11000) begin
      n_err++;
      $display("FAIL timeout_err: got err=%b to=%b cyc=%b stb=%b m1_err=%b, required 1 1 0 0 0",
               m0_err_o, timeout_o, s_cyc_o, s_stb_o, m1_err_o);
    end
    @(negedge clk);
    s_ack_i = 0;
    #1;
    n_vec++;
    if ({m0_err_o, timeout_o, grant_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL timeout_idle: got err=%b to=%b grant=%b, required 0 0 00",
               m0_err_o, timeout_o, grant_o);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_transfer();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 16'h0088; m1_dat_i = 32'h1234;
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_owner: got grant=%b cyc=%b, required 10 1", grant_o, s_cyc_o);
    end
    @(negedge clk);
    rst_n = 0; s_ack_i = 1;
    #1;
    n_vec++;
    if (m1_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_during: got m1_ack=%b cyc=%b, required 0 0", m1_ack_o, s_cyc_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m1_err_o, timeout_o} !== 8'h00 ||
        {s_adr_o, s_dat_o} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got grant=%b cyc=%b stb=%b we=%b ack=%b adr=%h, required all 0",
               grant_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o, s_adr_o);
    end
    @(negedge clk);
    rst_n = 1; m1_cyc_i = 0; m1_stb_i = 0;
    #1;
    n_vec++;
    if (m1_ack_o !== 1'b0 || grant_o !== 2'b00) begin
      n_err++;
      $display("FAIL rstmid_after: got m1_ack=%b grant=%b, required 0 00", m1_ack_o, grant_o);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_ack_drop();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1;
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b01) begin
      n_err++;
      $display("FAIL ackdrop_owner: got %b, required 01", grant_o);
    end
    @(negedge clk);
    s_ack_i = 1; s_dat_i = 32'hA5A5_A5A5; m0_cyc_i = 0; m0_stb_i = 0;
    exp_q.push_back({2'b01, 32'hA5A5_A5A5});
    #1;
    n_vec++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL ackdrop_fwd: got ack=%b dat=%h, required 1 a5a5a5a5", m0_ack_o, m0_dat_o);
    end
    @(negedge clk);
    s_ack_i = 0; s_dat_i = '0;
    #1;
    n_vec++;
    if (grant_o !== 2'b00) begin
      n_err++;
      $display("FAIL ackdrop_idle: got %b, required 00", grant_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if (grant_o !== 2'b10) begin
      n_err++;
      $display("FAIL ackdrop_next: got %b, required 10", grant_o);
    end
    clear_inputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_held_grant();
    test_timeout();
    test_reset_mid_transfer();
    test_ack_drop();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_acks: got %0d beats outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
